// File: rtl/bsg_fifo_word_splitter.sv
// Splits wide words from a valid/yumi source into ratio_p narrow chunks on a valid/ready link.
// Optional BSG_WORD_SPLITTER_MSB_FIRST_EN selects most-significant-chunk-first order.
module bsg_fifo_word_splitter #(
    parameter int width_p = 64,
    parameter int ratio_p = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       yumi_o,
    output logic                       v_o,
    output logic [width_p/ratio_p-1:0] data_o,
    output logic                       last_o,
    input  logic                       ready_i
);

    localparam int CW    = width_p / ratio_p;
    localparam int CNT_W = $clog2(ratio_p);

    logic [width_p-1:0] r_word;
    logic               r_full;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_last_cnt;
    logic               w_xfer;
    logic [CNT_W-1:0]   w_idx;

    assign w_last_cnt = (r_cnt == CNT_W'(ratio_p - 1));
    assign w_xfer     = r_full & ready_i;

    assign v_o    = r_full;
    assign last_o = r_full & w_last_cnt;
    // ready_i feeds yumi_o combinationally so a new word lands on the same edge the last chunk leaves.
    assign yumi_o = ~reset_i & v_i & (~r_full | (last_o & ready_i));

`ifdef BSG_WORD_SPLITTER_MSB_FIRST_EN
    assign w_idx = CNT_W'(ratio_p - 1) - r_cnt;
`else
    assign w_idx = r_cnt;
`endif

    assign data_o = r_word[w_idx*CW +: CW];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_word <= '0;
            r_full <= 1'b0;
            r_cnt  <= '0;
        end else if (yumi_o) begin
            r_word <= data_i;
            r_full <= 1'b1;
            r_cnt  <= '0;
        end else if (w_xfer) begin
            if (w_last_cnt) begin
                r_full <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
